// File: rtl/mux8_sched_pkg.sv
// Shared types and constants for the 8-way round-robin mux select scheduler.
package mux8_sched_pkg;

    localparam int N_REQ = 8;
    localparam int SEL_W = 3;
    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_GRANT,
        ST_GUARD
    } state_t;

    function automatic logic [N_REQ-1:0] onehot8(input logic [SEL_W-1:0] idx);
        logic [N_REQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/rr_pick8.sv
// Combinational round-robin picker: first set request after ptr, optionally skipping one index.
module rr_pick8
    import mux8_sched_pkg::*;
(
    input  logic [N_REQ-1:0] req,
    input  logic [SEL_W-1:0] ptr,
    input  logic [SEL_W-1:0] mask_idx,
    input  logic             mask_en,
    output logic             any,
    output logic [SEL_W-1:0] idx
);

    logic [SEL_W-1:0] cand;

    // Scan ptr+1 .. ptr+8; the 3-bit add wraps so ptr itself is considered last.
    always_comb begin
        any  = 1'b0;
        idx  = '0;
        cand = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ptr + SEL_W'(k);
            if (!any && req[cand] && !(mask_en && (cand == mask_idx))) begin
                any = 1'b1;
                idx = cand;
            end
        end
    end

endmodule

// File: rtl/mux8_rr_sched.sv
// Round-robin owner selection for the select lines of an 8:1 data mux,
// with bounded bursts and an optional idle guard cycle between owners.
module mux8_rr_sched
    import mux8_sched_pkg::*;
#(
    parameter int MAX_BURST = 4,
    parameter bit GUARD     = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [N_REQ-1:0] req,
    output logic [SEL_W-1:0] sel,
    output logic [N_REQ-1:0] gnt,
    output logic             active,
    output logic             handover
);

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] ptr_reg, ptr_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [N_REQ-1:0] gnt_reg, gnt_next;
    logic             handover_reg, handover_next;
    logic             active_reg;

    logic             pick_any;
    logic [SEL_W-1:0] pick_idx;
    logic             in_grant;
    logic             burst_done;
    logic             others;
    logic             release_now;

    assign in_grant = (state_reg == ST_GRANT);

    // While granting, the pick already uses the old owner as the pointer so a
    // back-to-back handover sees the updated rotation order.
    rr_pick8 u_pick (
        .req      (req),
        .ptr      (in_grant ? sel_reg : ptr_reg),
        .mask_idx (sel_reg),
        .mask_en  (in_grant),
        .any      (pick_any),
        .idx      (pick_idx)
    );

    assign burst_done  = (cnt_reg == CNT_W'(MAX_BURST));
    assign others      = |(req & ~gnt_reg);
    assign release_now = !req[sel_reg] || !en || (burst_done && others);

    always_comb begin
        state_next    = state_reg;
        ptr_next      = ptr_reg;
        cnt_next      = cnt_reg;
        sel_next      = sel_reg;
        gnt_next      = gnt_reg;
        handover_next = 1'b0;
        case (state_reg)
            ST_GRANT: begin
                if (release_now) begin
                    ptr_next = sel_reg;
                    gnt_next = '0;
                    if (!en) begin
                        state_next = ST_IDLE;
                    end else if (GUARD) begin
                        state_next = ST_GUARD;
                    end else if (pick_any) begin
                        state_next    = ST_GRANT;
                        sel_next      = pick_idx;
                        gnt_next      = onehot8(pick_idx);
                        cnt_next      = CNT_W'(1);
                        handover_next = 1'b1;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else if (burst_done) begin
                    cnt_next = CNT_W'(1);
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            default: begin
                // IDLE and GUARD share the same grant-start rule.
                gnt_next = '0;
                if (en && pick_any) begin
                    state_next    = ST_GRANT;
                    sel_next      = pick_idx;
                    gnt_next      = onehot8(pick_idx);
                    cnt_next      = CNT_W'(1);
                    handover_next = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            ptr_reg      <= SEL_W'(N_REQ - 1);
            cnt_reg      <= '0;
            sel_reg      <= '0;
            gnt_reg      <= '0;
            handover_reg <= 1'b0;
            active_reg   <= 1'b0;
        end else begin
            state_reg    <= state_next;
            ptr_reg      <= ptr_next;
            cnt_reg      <= cnt_next;
            sel_reg      <= sel_next;
            gnt_reg      <= gnt_next;
            handover_reg <= handover_next;
            active_reg   <= |gnt_next;
        end
    end

    assign sel      = sel_reg;
    assign gnt      = gnt_reg;
    assign active   = active_reg;
    assign handover = handover_reg;

endmodule
